wt_mac: RTL and testbench
=========================

Name: wt_mac

Overview:
- Pipelined signed multiply-accumulate stage that sits directly downstream of the wt_s Wallace-tree multiplier and instantiates it.
- Registers 16-bit operands, captures the 32-bit wt_s product, then loads, adds or subtracts it into a wide accumulator.
- Uses valid/ready handshakes on input and output, so it can be driven by a host FSM or a UART command decoder on the icestick.

Parameters:
- ACC_W, 40, accumulator/result width in bits; legal range 32..48.
- SAT, 1, 1 = saturate on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept this cycle.
- a  in  16  signed multiplicand.
- b  in  16  signed multiplier.
- op  in  2  00 MUL (acc=p), 01 MAC (acc+=p), 10 MSU (acc-=p), 11 CLR (acc=0, ovf=0).
- out_valid  out  1  result held on acc_out.
- out_ready  in  1  consumer accepts result.
- acc_out  out  ACC_W  accumulator value after the op.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (async, any time, including mid-operation): all stage valids=0, out_valid=0, acc_out=0, internal acc=0, ovf=0. In-flight ops are discarded.
- Pipeline stages:
  - S1: registers a, b, op.
  - S2: registers the wt_s product C. wt_s alufn is tied 0 (signed).
  - S3: updates acc and the output register.
- Latency: 3 cycles from input handshake (in_valid&in_ready) to out_valid=1 at the earliest.
- Throughput: 1 op/cycle with no backpressure. Back-to-back MACs are correct because acc is read and written only in S3.
- Advance: adv = !out_valid | out_ready. All stages shift on adv and hold otherwise. in_ready = adv (combinational).
- Bubbles: an empty stage shifts a bubble. out_valid is set when a valid op leaves S2 on adv, and cleared on out_ready when no valid op is arriving.
- Output stability: out_valid and acc_out must not change while out_valid=1 and out_ready=0.
- Width rules: the product is sign-extended to ACC_W. The sum/difference is computed at ACC_W+1 bits.
- Overflow: detected when the top two bits of the ACC_W+1 result differ.
  - SAT=1: clamp to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow).
  - SAT=0: keep the low ACC_W bits.
  - ovf is set on either overflow case and holds until CLR or rst. MUL cannot overflow and leaves ovf unchanged.
- CLR: flows through the pipeline like other ops and produces an output beat with acc_out=0.
- Special operands: -32768 * -32768 = +2^30 must be exact (wt_s signed path).

Decomposition:
- Shared package (wt_pkg): OP_MUL/OP_MAC/OP_MSU/OP_CLR encodings, OPW=16, PRODW=32.
- One sub-module: the existing wt_s, instantiated in S2. No new sub-modules.
- Saturation logic stays inline.

Test Plan:
- MUL a=36,b=36 with out_ready=1 -> after 3 cycles out_valid=1, acc_out=1296, ovf=0.
- Then MAC a=-36,b=36 back-to-back, followed by MSU a=-36,b=-36 -> successive outputs 0, then -1296 (sign-extended), one per cycle.
- Backpressure: issue 4 MACs of 0x7FFF*0x7FFF with out_ready=0 for 10 cycles -> in_ready drops once the pipe is full, acc_out frozen on the first result. Release out_ready -> 4 results in order, no loss or duplication; final acc=4*1073676289.
- Saturation with ACC_W=32, SAT=1: MUL -32768*-32768 then MAC same -> acc_out=0x7FFFFFFF, ovf=1. CLR -> acc_out=0, ovf=0.
- Same sequence with SAT=0 -> acc_out=0x80000000, ovf=1.
- Assert rst for 1 cycle while 2 ops are in flight -> out_valid=0, acc_out=0 immediately. Next MUL 0*36 -> acc_out=0 with no stale output beat.

Source files
------------

// File: rtl/wt_pkg.sv
// Shared operand/product widths and op encodings for the wt_s multiplier and the wt_mac stage.
package wt_pkg;

   localparam int OPW   = 16;
   localparam int PRODW = 32;

   typedef enum logic [1:0] {
      OP_MUL = 2'b00,
      OP_MAC = 2'b01,
      OP_MSU = 2'b10,
      OP_CLR = 2'b11
   } op_e;

endpackage

// File: rtl/wt_s.sv
// Combinational 16x16 Wallace-tree multiplier; alufn=0 multiplies signed operands, alufn=1 unsigned.
module wt_s
   import wt_pkg::*;
(
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   input  logic             alufn,
   output logic [PRODW-1:0] c
);

   localparam int NROW = OPW + 1;

   function automatic logic [PRODW-1:0] wallace_mul(
      input logic [OPW-1:0] x,
      input logic [OPW-1:0] y,
      input logic           uns
   );
      logic [PRODW-1:0] row [NROW];
      logic [PRODW-1:0] nxt [NROW];
      logic [PRODW-1:0] xe;
      int               n;
      int               m;

      xe = {{(PRODW-OPW){x[OPW-1] & ~uns}}, x};
      for (int i = 0; i < OPW; i++) begin
         if (y[i]) row[i] = xe << i;
         else      row[i] = '0;
      end
      // Signed multiplier MSB has negative weight: add ~(x<<15) + 1.
      if (!uns && y[OPW-1]) begin
         row[OPW-1] = ~(xe << (OPW-1));
         row[OPW]   = 32'd1;
      end else begin
         row[OPW]   = '0;
      end

      n = NROW;
      for (int lvl = 0; lvl < 6; lvl++) begin
         m = 0;
         for (int i = 0; i < NROW; i++) nxt[i] = '0;
         for (int g = 0; g < NROW / 3; g++) begin
            if (3 * g + 2 < n) begin
               nxt[m[4:0]]      = row[3*g] ^ row[3*g+1] ^ row[3*g+2];
               nxt[m[4:0] + 5'd1] = ((row[3*g] & row[3*g+1]) |
                                   (row[3*g] & row[3*g+2]) |
                                   (row[3*g+1] & row[3*g+2])) << 1;
               m = m + 2;
            end
         end
         for (int i = 0; i < NROW; i++) begin
            if (i >= (n / 3) * 3 && i < n) begin
               nxt[m[4:0]] = row[i];
               m = m + 1;
            end
         end
         for (int i = 0; i < NROW; i++) row[i] = nxt[i];
         n = m;
      end
      return row[0] + row[1];
   endfunction

   assign c = wallace_mul(a, b, alufn);

endmodule

// File: rtl/wt_mac.sv
// Three-stage signed multiply-accumulate around wt_s with valid/ready handshakes,
// a sticky overflow flag and optional saturation of the accumulator.
module wt_mac
   import wt_pkg::*;
#(
   parameter int ACC_W = 40,
   parameter bit SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic             v1_q, v1_d;
   logic [OPW-1:0]   a1_q, a1_d;
   logic [OPW-1:0]   b1_q, b1_d;
   op_e              op1_q, op1_d;
   logic             v2_q, v2_d;
   logic [PRODW-1:0] prod_q, prod_d;
   op_e              op2_q, op2_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic             adv_s;
   logic [PRODW-1:0] prod_s;
   logic [ACC_W-1:0] prod_ext_s;
   logic [ACC_W:0]   sum_s;
   logic             sum_ovf_s;
   logic [ACC_W-1:0] sum_res_s;

   wt_s u_wt_s (
      .a     (a1_q),
      .b     (b1_q),
      .alufn (1'b0),
      .c     (prod_s)
   );

   // One guard bit above the accumulator exposes overflow as a sign mismatch.
   always_comb begin
      adv_s      = ~out_valid_q | out_ready;
      prod_ext_s = {ACC_W{prod_q[PRODW-1]}};
      prod_ext_s[PRODW-1:0] = prod_q;
      if (op2_q == OP_MSU) begin
         sum_s = {acc_q[ACC_W-1], acc_q} - {prod_ext_s[ACC_W-1], prod_ext_s};
      end else begin
         sum_s = {acc_q[ACC_W-1], acc_q} + {prod_ext_s[ACC_W-1], prod_ext_s};
      end
      sum_ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
      if (!sum_ovf_s) begin
         sum_res_s = sum_s[ACC_W-1:0];
      end else if (SAT) begin
         sum_res_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         sum_res_s = sum_s[ACC_W-1:0];
      end
   end

   always_comb begin
      v1_d        = v1_q;
      a1_d        = a1_q;
      b1_d        = b1_q;
      op1_d       = op1_q;
      v2_d        = v2_q;
      prod_d      = prod_q;
      op2_d       = op2_q;
      out_valid_d = out_valid_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      if (adv_s) begin
         v1_d        = in_valid;
         a1_d        = a;
         b1_d        = b;
         op1_d       = op_e'(op);
         v2_d        = v1_q;
         prod_d      = prod_s;
         op2_d       = op1_q;
         out_valid_d = v2_q;
         if (v2_q) begin
            case (op2_q)
               OP_MUL: acc_d = prod_ext_s;
               OP_MAC, OP_MSU: begin
                  acc_d = sum_res_s;
                  ovf_d = ovf_q | sum_ovf_s;
               end
               OP_CLR: begin
                  acc_d = '0;
                  ovf_d = 1'b0;
               end
               default: acc_d = acc_q;
            endcase
         end else begin
            acc_d = acc_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q        <= 1'b0;
         a1_q        <= '0;
         b1_q        <= '0;
         op1_q       <= OP_MUL;
         v2_q        <= 1'b0;
         prod_q      <= '0;
         op2_q       <= OP_MUL;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         v1_q        <= v1_d;
         a1_q        <= a1_d;
         b1_q        <= b1_d;
         op1_q       <= op1_d;
         v2_q        <= v2_d;
         prod_q      <= prod_d;
         op2_q       <= op2_d;
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready  = adv_s;
   assign out_valid = out_valid_q;
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_wt_mac.sv
// Randomised and directed bench for wt_mac: three configurations share one stimulus stream
// and each is scored against an arithmetic reference model with an expected-result queue.
module tb_wt_mac;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic [1:0]  op;
   logic        out_ready;

   logic        in_ready0, in_ready1, in_ready2;
   logic        out_valid0, out_valid1, out_valid2;
   logic [39:0] acc_out0;
   logic [31:0] acc_out1, acc_out2;
   logic        ovf0, ovf1, ovf2;

   always #5 clk = ~clk;

   wt_mac #(.ACC_W(40), .SAT(1'b1)) u_dut40 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b), .op(op),
      .out_valid(out_valid0), .out_ready(out_ready), .acc_out(acc_out0), .ovf(ovf0));
   wt_mac #(.ACC_W(32), .SAT(1'b1)) u_dut32s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b), .op(op),
      .out_valid(out_valid1), .out_ready(out_ready), .acc_out(acc_out1), .ovf(ovf1));
   wt_mac #(.ACC_W(32), .SAT(1'b0)) u_dut32w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .op(op),
      .out_valid(out_valid2), .out_ready(out_ready), .acc_out(acc_out2), .ovf(ovf2));

   int     n_tests = 0;
   int     n_fail  = 0;
   int     acc_w [NI] = '{40, 32, 32};
   bit     sat   [NI] = '{1'b1, 1'b1, 1'b0};
   longint m_acc [NI];
   bit     m_ovf [NI];
   longint q_acc [NI][$];
   bit     q_ovf [NI][$];
   bit     stall_prev [NI];
   longint prev_acc [NI];
   longint last_acc [NI];
   longint last_ovf [NI];
   bit     accepted;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic longint obs_acc(input int i);
      case (i)
         0:       return longint'($signed(acc_out0));
         1:       return longint'($signed(acc_out1));
         default: return longint'($signed(acc_out2));
      endcase
   endfunction

   function automatic longint obs_ov(input int i);
      case (i)
         0:       return longint'(out_valid0);
         1:       return longint'(out_valid1);
         default: return longint'(out_valid2);
      endcase
   endfunction

   function automatic longint obs_ovf(input int i);
      case (i)
         0:       return longint'(ovf0);
         1:       return longint'(ovf1);
         default: return longint'(ovf2);
      endcase
   endfunction

   function automatic int pending();
      return q_acc[0].size() + q_acc[1].size() + q_acc[2].size();
   endfunction

   // Reference: exact integer arithmetic, then clamp or wrap into the accumulator range.
   task automatic model_op(input logic [15:0] xa, input logic [15:0] xb, input logic [1:0] xop);
      longint p, r, mx, mn, span;
      p = longint'($signed(xa)) * longint'($signed(xb));
      for (int i = 0; i < NI; i++) begin
         span = 64'sd1 <<< acc_w[i];
         mx   = (64'sd1 <<< (acc_w[i] - 1)) - 64'sd1;
         mn   = -mx - 64'sd1;
         case (xop)
            2'b00: m_acc[i] = p;
            2'b11: begin
               m_acc[i] = 64'sd0;
               m_ovf[i] = 1'b0;
            end
            default: begin
               r = (xop == 2'b01) ? m_acc[i] + p : m_acc[i] - p;
               if (r > mx || r < mn) begin
                  m_ovf[i] = 1'b1;
                  if (sat[i]) begin
                     m_acc[i] = (r > mx) ? mx : mn;
                  end else begin
                     r = r & (span - 64'sd1);
                     if (r > mx) r = r - span;
                     m_acc[i] = r;
                  end
               end else begin
                  m_acc[i] = r;
               end
            end
         endcase
         q_acc[i].push_back(m_acc[i]);
         q_ovf[i].push_back(m_ovf[i]);
      end
   endtask

   task automatic sample();
      longint e_acc;
      bit     e_ovf;
      for (int i = 0; i < NI; i++) begin
         if (stall_prev[i]) begin
            check_val($sformatf("hold_valid%0d", i), obs_ov(i), 64'sd1);
            check_val($sformatf("hold_acc%0d", i), obs_acc(i), prev_acc[i]);
         end
      end
      accepted = in_valid && in_ready0;
      if (accepted) model_op(a, b, op);
      for (int i = 0; i < NI; i++) begin
         if (obs_ov(i) == 64'sd1 && out_ready) begin
            if (q_acc[i].size() == 0) begin
               check_val($sformatf("extra_beat%0d", i), 64'sd1, 64'sd0);
            end else begin
               e_acc = q_acc[i].pop_front();
               e_ovf = q_ovf[i].pop_front();
               check_val($sformatf("acc%0d", i), obs_acc(i), e_acc);
               check_val($sformatf("ovf%0d", i), obs_ovf(i), longint'(e_ovf));
               last_acc[i] = obs_acc(i);
               last_ovf[i] = obs_ovf(i);
            end
         end
         stall_prev[i] = (obs_ov(i) == 64'sd1) && !out_ready;
         prev_acc[i]   = obs_acc(i);
      end
   endtask

   task automatic step(input bit v, input logic [15:0] xa, input logic [15:0] xb,
                       input logic [1:0] xop, input bit ordy);
      @(negedge clk);
      in_valid  = v;
      a         = xa;
      b         = xb;
      op        = xop;
      out_ready = ordy;
      #1;
      sample();
   endtask

   task automatic issue(input logic [15:0] xa, input logic [15:0] xb,
                        input logic [1:0] xop, input bit ordy);
      bit done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (!done) begin
            step(1'b1, xa, xb, xop, ordy);
            done = accepted;
         end
      end
      if (!done) check_val("issue_timeout", 64'sd0, 64'sd1);
   endtask

   task automatic drain();
      int k = 0;
      while (pending() > 0 && k < 30) begin
         step(1'b0, 16'd0, 16'd0, 2'b00, 1'b1);
         k++;
      end
      if (pending() != 0) check_val("drain_timeout", longint'(pending()), 64'sd0);
      step(1'b0, 16'd0, 16'd0, 2'b00, 1'b1);
   endtask

   task automatic clear_model();
      for (int i = 0; i < NI; i++) begin
         m_acc[i] = 64'sd0;
         m_ovf[i] = 1'b0;
         q_acc[i].delete();
         q_ovf[i].delete();
         stall_prev[i] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra, rb;
      logic [1:0]  rop;
      rst = 1'b1; in_valid = 1'b0; a = 16'd0; b = 16'd0; op = 2'b00; out_ready = 1'b1;
      clear_model();
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check_val($sformatf("rst_valid%0d", i), obs_ov(i), 64'sd0);
         check_val($sformatf("rst_acc%0d", i), obs_acc(i), 64'sd0);
         check_val($sformatf("rst_ovf%0d", i), obs_ovf(i), 64'sd0);
      end
      check_val("rst_in_ready", longint'(in_ready0), 64'sd1);
      rst = 1'b0;

      // Latency: result visible in the third cycle after the handshake, not before.
      issue(16'd36, 16'd36, 2'b00, 1'b1);
      step(1'b0, 16'd0, 16'd0, 2'b00, 1'b1);
      step(1'b0, 16'd0, 16'd0, 2'b00, 1'b1);
      check_val("lat_early", longint'(out_valid0), 64'sd0);
      step(1'b0, 16'd0, 16'd0, 2'b00, 1'b1);
      check_val("lat_valid", longint'(out_valid0), 64'sd1);
      check_val("mul_1296", last_acc[0], 64'sd1296);

      issue(16'hFFDC, 16'd36, 2'b01, 1'b1);
      issue(16'hFFDC, 16'hFFDC, 2'b10, 1'b1);
      drain();
      check_val("msu_neg1296", last_acc[1], -64'sd1296);

      // Backpressure: fill the pipe with out_ready low, then release.
      issue(16'd0, 16'd0, 2'b11, 1'b1);
      drain();
      for (int k = 0; k < 3; k++) issue(16'h7FFF, 16'h7FFF, 2'b01, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b1, 16'h7FFF, 16'h7FFF, 2'b01, 1'b0);
      check_val("bp_in_ready", longint'(in_ready0), 64'sd0);
      check_val("bp_held", longint'(out_valid0), 64'sd1);
      issue(16'h7FFF, 16'h7FFF, 2'b01, 1'b1);
      drain();
      check_val("bp_final40", last_acc[0], 64'sd4294705156);
      check_val("bp_final32s", last_acc[1], 64'sd2147483647);
      check_val("bp_final32w", last_acc[2], -64'sd262140);

      // -32768 * -32768 twice: overflows a 32-bit accumulator.
      issue(16'd0, 16'd0, 2'b11, 1'b1);
      issue(16'h8000, 16'h8000, 2'b00, 1'b1);
      issue(16'h8000, 16'h8000, 2'b01, 1'b1);
      drain();
      check_val("sat_acc", last_acc[1], 64'sd2147483647);
      check_val("sat_ovf", last_ovf[1], 64'sd1);
      check_val("wrap_acc", last_acc[2], -64'sd2147483648);
      check_val("wrap_ovf", last_ovf[2], 64'sd1);
      check_val("wide_acc", last_acc[0], 64'sd2147483648);
      check_val("wide_ovf", last_ovf[0], 64'sd0);
      issue(16'd0, 16'd0, 2'b11, 1'b1);
      drain();
      check_val("clr_acc", last_acc[1], 64'sd0);
      check_val("clr_ovf", last_ovf[1], 64'sd0);

      // Asynchronous reset with operations in flight.
      issue(16'd7, 16'd7, 2'b00, 1'b1);
      issue(16'd3, 16'd3, 2'b01, 1'b1);
      issue(16'd2, 16'd2, 2'b01, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         check_val($sformatf("arst_valid%0d", i), obs_ov(i), 64'sd0);
         check_val($sformatf("arst_acc%0d", i), obs_acc(i), 64'sd0);
      end
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) step(1'b0, 16'd0, 16'd0, 2'b00, 1'b1);
      issue(16'd0, 16'd36, 2'b00, 1'b1);
      drain();
      check_val("post_rst_acc", last_acc[0], 64'sd0);

      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0:       ra = 16'h8000;
            1:       ra = 16'h7FFF;
            default: ra = 16'($urandom());
         endcase
         case ($urandom_range(0, 9))
            0:       rb = 16'h8000;
            1:       rb = 16'h7FFF;
            default: rb = 16'($urandom());
         endcase
         rop = 2'($urandom_range(0, 3));
         if (rop == 2'b11 && $urandom_range(0, 3) != 0) rop = 2'b01;
         step($urandom_range(0, 99) < 70, ra, rb, rop, $urandom_range(0, 99) < 75);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
